// File: rtl/pcma_mode_scanner.sv
// PCMA mode scanner: debounces the lock detector's decisions, scans fm4/fm8
// and sequences the detector's reset. Optional watchdog: PCMA_SCAN_WDOG_EN.
module pcma_mode_scanner #(
    parameter int RST_CYCLES   = 8,
    parameter int CNT_WIDTH    = 8,
    parameter int SWITCH_WIDTH = 16,
    parameter int WDOG_WIDTH   = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable_i,
    input  logic                    lock_val_i,
    input  logic                    lock_i,
    input  logic [CNT_WIDTH-1:0]    seek_tries_i,
    input  logic [3:0]              confirm_i,
    input  logic [3:0]              lose_i,
    output logic                    det_reset_n_o,
    output logic [2:0]              mode_o,
    output logic                    locked_o,
    output logic [SWITCH_WIDTH-1:0] switch_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        RESET_DET,
        SEEK,
        LOCKED
    } state_t;

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
    localparam logic [2:0] MODE_FM4 = 3'b001;
    localparam logic [2:0] MODE_FM8 = 3'b010;

    state_t                  state;
    logic [RW-1:0]           rst_cnt;
    logic [CNT_WIDTH-1:0]    try_cnt;
    logic [CNT_WIDTH-1:0]    hit_cnt;
    logic [CNT_WIDTH-1:0]    miss_cnt;
`ifdef PCMA_SCAN_WDOG_EN
    logic [WDOG_WIDTH-1:0]   wdog_cnt;
`endif

    logic [CNT_WIDTH-1:0]    tries_th;
    logic [CNT_WIDTH-1:0]    conf_th;
    logic [CNT_WIDTH-1:0]    lose_th;
    logic [CNT_WIDTH-1:0]    try_inc;
    logic [CNT_WIDTH-1:0]    hit_inc;
    logic [CNT_WIDTH-1:0]    miss_inc;
    logic [SWITCH_WIDTH-1:0] switch_inc;
    logic [2:0]              mode_next;

    // Live thresholds (zero means one) and saturating increments
    always_comb begin
        tries_th   = (seek_tries_i == '0) ? CNT_WIDTH'(1) : seek_tries_i;
        conf_th    = (confirm_i == 4'd0) ? CNT_WIDTH'(1) : CNT_WIDTH'(confirm_i);
        lose_th    = (lose_i == 4'd0) ? CNT_WIDTH'(1) : CNT_WIDTH'(lose_i);
        try_inc    = (&try_cnt) ? try_cnt : try_cnt + CNT_WIDTH'(1);
        hit_inc    = (&hit_cnt) ? hit_cnt : hit_cnt + CNT_WIDTH'(1);
        miss_inc   = (&miss_cnt) ? miss_cnt : miss_cnt + CNT_WIDTH'(1);
        switch_inc = (&switch_cnt_o) ? switch_cnt_o
                                     : switch_cnt_o + SWITCH_WIDTH'(1);
        mode_next  = (mode_o == MODE_FM4) ? MODE_FM8 : MODE_FM4;
    end

    // Scanner state machine with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            det_reset_n_o <= 1'b0;
            mode_o        <= MODE_FM4;
            locked_o      <= 1'b0;
            switch_cnt_o  <= '0;
            rst_cnt       <= '0;
            try_cnt       <= '0;
            hit_cnt       <= '0;
            miss_cnt      <= '0;
`ifdef PCMA_SCAN_WDOG_EN
            wdog_cnt      <= '0;
`endif
        end else if (!enable_i) begin
            state         <= IDLE;
            det_reset_n_o <= 1'b0;
            locked_o      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state         <= RESET_DET;
                    rst_cnt       <= '0;
                    det_reset_n_o <= 1'b0;
                    locked_o      <= 1'b0;
                end
                RESET_DET: begin
                    if (rst_cnt == RST_LAST) begin
                        state         <= SEEK;
                        det_reset_n_o <= 1'b1;
                        try_cnt       <= '0;
                        hit_cnt       <= '0;
                        miss_cnt      <= '0;
`ifdef PCMA_SCAN_WDOG_EN
                        wdog_cnt      <= '0;
`endif
                    end else begin
                        rst_cnt <= rst_cnt + RW'(1);
                    end
                end
                SEEK: begin
                    if (lock_val_i) begin
`ifdef PCMA_SCAN_WDOG_EN
                        wdog_cnt <= '0;
`endif
                        if (lock_i) begin
                            if (hit_inc >= conf_th) begin
                                state    <= LOCKED;
                                locked_o <= 1'b1;
                                miss_cnt <= '0;
                                hit_cnt  <= '0;
                            end else begin
                                hit_cnt <= hit_inc;
                            end
                        end else begin
                            hit_cnt <= '0;
                            if (try_inc >= tries_th) begin
                                state         <= RESET_DET;
                                det_reset_n_o <= 1'b0;
                                rst_cnt       <= '0;
                                mode_o        <= mode_next;
                                switch_cnt_o  <= switch_inc;
                                try_cnt       <= '0;
                            end else begin
                                try_cnt <= try_inc;
                            end
                        end
`ifdef PCMA_SCAN_WDOG_EN
                    end else if (&wdog_cnt) begin
                        state         <= RESET_DET;
                        det_reset_n_o <= 1'b0;
                        rst_cnt       <= '0;
                        locked_o      <= 1'b0;
                        wdog_cnt      <= '0;
                    end else begin
                        wdog_cnt <= wdog_cnt + WDOG_WIDTH'(1);
`endif
                    end
                end
                LOCKED: begin
                    if (lock_val_i) begin
`ifdef PCMA_SCAN_WDOG_EN
                        wdog_cnt <= '0;
`endif
                        if (lock_i) begin
                            miss_cnt <= '0;
                        end else if (miss_inc >= lose_th) begin
                            state    <= SEEK;
                            locked_o <= 1'b0;
                            try_cnt  <= '0;
                            hit_cnt  <= '0;
                            miss_cnt <= '0;
                        end else begin
                            miss_cnt <= miss_inc;
                        end
`ifdef PCMA_SCAN_WDOG_EN
                    end else if (&wdog_cnt) begin
                        state         <= RESET_DET;
                        det_reset_n_o <= 1'b0;
                        rst_cnt       <= '0;
                        locked_o      <= 1'b0;
                        wdog_cnt      <= '0;
                    end else begin
                        wdog_cnt <= wdog_cnt + WDOG_WIDTH'(1);
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
